ahb_lsu: RTL



---
 rtl/ahb_pkg.sv | 40 ++++
 rtl/ahb_lsu_lane.sv | 33 +++
 rtl/ahb_lsu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the LSU access-size type used by ahb_lsu
// and its lane helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_size_t;

    // The reserved encoding 3 behaves as a word access.
    function automatic lsu_size_t lsu_size_norm(input logic [1:0] raw);
        case (raw)
            2'd0:    return LSU_BYTE;
            2'd1:    return LSU_HALF;
            default: return LSU_WORD;
        endcase
    endfunction

    function automatic logic [2:0] lsu_hsize(input lsu_size_t s);
        case (s)
            LSU_BYTE: return HSIZE_BYTE;
            LSU_HALF: return HSIZE_HALF;
            default:  return HSIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lsu_lane.sv
// Byte-lane steering for ahb_lsu: shifts store data onto its AHB lanes and
// extracts / sign- or zero-extends load data from hrdata.
module ahb_lsu_lane
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            addr_lo,
    input  lsu_size_t             size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [DATA_WIDTH-1:0] st_lane,
    output logic [DATA_WIDTH-1:0] ld_ext
);

    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] ld_shift;

    assign shamt    = {addr_lo, 3'b000};
    assign st_lane  = st_data << shamt;
    assign ld_shift = ld_data >> shamt;

    always_comb begin
        ld_ext = ld_shift;
        case (size)
            LSU_BYTE: ld_ext = {{(DATA_WIDTH-8){~is_unsigned & ld_shift[7]}}, ld_shift[7:0]};
            LSU_HALF: ld_ext = {{(DATA_WIDTH-16){~is_unsigned & ld_shift[15]}}, ld_shift[15:0]};
            default:  ld_ext = ld_shift;
        endcase
    end

endmodule

// File: rtl/ahb_lsu.sv
// Core-side load/store unit: single AHB-Lite master with a registered address
// stage and data stage. Optional macro AHB_LSU_MISALIGN_CHECK_EN rejects
// misaligned half/word accesses instead of forcing them aligned.
module ahb_lsu
    import ahb_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESET,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,

    output logic                  hsel,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic                  hmastlock,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    logic                  accept;
    logic                  err_hold;
    logic                  req_mis;
    lsu_size_t             req_sz;
    logic [ADDR_WIDTH-1:0] req_addr_al;

    logic                  ap_valid;
    logic                  ap_bypass;
    logic                  ap_write;
    logic                  ap_unsigned;
    lsu_size_t             ap_size;
    logic [ADDR_WIDTH-1:0] ap_addr;
    logic [DATA_WIDTH-1:0] ap_wdata;

    logic                  dp_valid;
    logic                  dp_bypass;
    logic                  dp_write;
    logic                  dp_unsigned;
    lsu_size_t             dp_size;
    logic [1:0]            dp_addr_lo;
    logic [DATA_WIDTH-1:0] dp_wdata;

    logic                  dp_done;
    logic                  bus_err;
    logic [DATA_WIDTH-1:0] st_lane;
    logic [DATA_WIDTH-1:0] ld_ext;

    assign req_ready = hready & ~err_hold;
    assign accept    = req_valid & req_ready;
    assign req_sz    = lsu_size_norm(req_size);

`ifdef AHB_LSU_MISALIGN_CHECK_EN
    always_comb begin
        req_mis = 1'b0;
        case (req_sz)
            LSU_HALF: req_mis = req_addr[0];
            LSU_WORD: req_mis = |req_addr[1:0];
            default:  req_mis = 1'b0;
        endcase
    end

    assign req_addr_al = req_addr;
`else
    assign req_mis = 1'b0;

    always_comb begin
        req_addr_al = req_addr;
        case (req_sz)
            LSU_HALF: req_addr_al[0]   = 1'b0;
            LSU_WORD: req_addr_al[1:0] = 2'b00;
            default:  req_addr_al      = req_addr;
        endcase
    end
`endif

    // A rejected (bypass) request rides the AP/DP slots without driving the
    // bus, which keeps its response in order and at the normal latency.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ap_valid    <= 1'b0;
            ap_bypass   <= 1'b0;
            ap_write    <= 1'b0;
            ap_unsigned <= 1'b0;
            ap_size     <= LSU_BYTE;
            ap_addr     <= '0;
            ap_wdata    <= '0;
        end else if (hready) begin
            ap_valid  <= accept & ~req_mis;
            ap_bypass <= accept & req_mis;
            if (accept) begin
                ap_write    <= req_write;
                ap_unsigned <= req_unsigned;
                ap_size     <= req_sz;
                ap_addr     <= req_addr_al;
                ap_wdata    <= req_wdata;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid    <= 1'b0;
            dp_bypass   <= 1'b0;
            dp_write    <= 1'b0;
            dp_unsigned <= 1'b0;
            dp_size     <= LSU_BYTE;
            dp_addr_lo  <= 2'b00;
            dp_wdata    <= '0;
        end else if (hready) begin
            dp_valid    <= ap_valid;
            dp_bypass   <= ap_bypass;
            dp_write    <= ap_write;
            dp_unsigned <= ap_unsigned;
            dp_size     <= ap_size;
            dp_addr_lo  <= ap_addr[1:0];
            dp_wdata    <= ap_wdata;
        end
    end

    ahb_lsu_lane #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .addr_lo     (dp_addr_lo),
        .size        (dp_size),
        .is_unsigned (dp_unsigned),
        .st_data     (dp_wdata),
        .ld_data     (hrdata),
        .st_lane     (st_lane),
        .ld_ext      (ld_ext)
    );

    assign dp_done = hready & (dp_valid | dp_bypass);
    assign bus_err = dp_bypass | (dp_valid & (hresp == HRESP_ERROR));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            err_hold  <= 1'b0;
        end else begin
            rsp_valid <= dp_done;
            rsp_error <= dp_done & bus_err;
            rsp_rdata <= (dp_done & dp_valid & ~dp_write & (hresp == HRESP_OKAY)) ? ld_ext : '0;
            err_hold  <= dp_done & dp_valid & (hresp == HRESP_ERROR);
        end
    end

    assign htrans    = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsel      = htrans[1];
    assign haddr     = ap_addr;
    assign hwrite    = ap_write;
    assign hsize     = lsu_hsize(ap_size);
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;
    assign hwdata    = (dp_valid & dp_write) ? st_lane : '0;

endmodule
